// File: rtl/mcu51_pkg.sv
// Shared definitions for the MCU51 accumulator/ALU sequencer: ALU op codes,
// accepted opcodes, sequencer states and the per-instruction flag write mask.
package mcu51_pkg;

  localparam logic [3:0] ALU_INC  = 4'b0000;
  localparam logic [3:0] ALU_DEC  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDC = 4'b0011;
  localparam logic [3:0] ALU_ORL  = 4'b0100;
  localparam logic [3:0] ALU_ANL  = 4'b0101;
  localparam logic [3:0] ALU_XRL  = 4'b0110;
  localparam logic [3:0] ALU_CPL  = 4'b0111;
  localparam logic [3:0] ALU_DA   = 4'b1000;
  localparam logic [3:0] ALU_SUBB = 4'b1001;
  localparam logic [3:0] ALU_RR   = 4'b1100;
  localparam logic [3:0] ALU_RRC  = 4'b1101;
  localparam logic [3:0] ALU_RL   = 4'b1110;
  localparam logic [3:0] ALU_RLC  = 4'b1111;

  localparam logic [7:0] OP_INC_A = 8'h04;
  localparam logic [7:0] OP_DEC_A = 8'h14;
  localparam logic [7:0] OP_ADD_I = 8'h24;
  localparam logic [7:0] OP_ADDC_I = 8'h34;
  localparam logic [7:0] OP_ORL_I = 8'h44;
  localparam logic [7:0] OP_ANL_I = 8'h54;
  localparam logic [7:0] OP_XRL_I = 8'h64;
  localparam logic [7:0] OP_CPL_A = 8'hF4;
  localparam logic [7:0] OP_DA_A  = 8'hD4;
  localparam logic [7:0] OP_SUBB_I = 8'h94;
  localparam logic [7:0] OP_RR_A  = 8'h03;
  localparam logic [7:0] OP_RRC_A = 8'h13;
  localparam logic [7:0] OP_RL_A  = 8'h23;
  localparam logic [7:0] OP_RLC_A = 8'h33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IMM  = 2'd1,
    EXEC = 2'd2
  } state_e;

  typedef struct packed {
    logic cy_en;
    logic ac_en;
    logic ov_en;
  } flag_mask_t;

  localparam flag_mask_t MASK_NONE = '{cy_en: 1'b0, ac_en: 1'b0, ov_en: 1'b0};
  localparam flag_mask_t MASK_CY   = '{cy_en: 1'b1, ac_en: 1'b0, ov_en: 1'b0};
  localparam flag_mask_t MASK_ALL  = '{cy_en: 1'b1, ac_en: 1'b1, ov_en: 1'b1};

  typedef struct packed {
    logic       legal;
    logic       two_byte;
    logic [3:0] alu_code;
    flag_mask_t flag_mask;
  } op_info_t;

endpackage

// File: rtl/mcu51_op_decode.sv
// Combinational opcode decoder: legality, instruction length, ALU op and the
// set of PSW flags the instruction is allowed to write.
module mcu51_op_decode
  import mcu51_pkg::*;
(
  input  logic [7:0] opcode_i,
  output op_info_t   info_o
);

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    info_o = '{legal: 1'b1, two_byte: 1'b0, alu_code: ALU_INC, flag_mask: MASK_NONE};
    case (opcode_i)
      OP_INC_A:  info_o.alu_code = ALU_INC;
      OP_DEC_A:  info_o.alu_code = ALU_DEC;
      OP_ADD_I: begin
        info_o.alu_code  = ALU_ADD;
        info_o.two_byte  = 1'b1;
        info_o.flag_mask = MASK_ALL;
      end
      OP_ADDC_I: begin
        info_o.alu_code  = ALU_ADDC;
        info_o.two_byte  = 1'b1;
        info_o.flag_mask = MASK_ALL;
      end
      OP_ORL_I: begin
        info_o.alu_code = ALU_ORL;
        info_o.two_byte = 1'b1;
      end
      OP_ANL_I: begin
        info_o.alu_code = ALU_ANL;
        info_o.two_byte = 1'b1;
      end
      OP_XRL_I: begin
        info_o.alu_code = ALU_XRL;
        info_o.two_byte = 1'b1;
      end
      OP_CPL_A:  info_o.alu_code = ALU_CPL;
      OP_DA_A: begin
        info_o.alu_code  = ALU_DA;
        info_o.flag_mask = MASK_CY;
      end
      OP_SUBB_I: begin
        info_o.alu_code  = ALU_SUBB;
        info_o.two_byte  = 1'b1;
        info_o.flag_mask = MASK_ALL;
      end
      OP_RR_A:   info_o.alu_code = ALU_RR;
      OP_RRC_A: begin
        info_o.alu_code  = ALU_RRC;
        info_o.flag_mask = MASK_CY;
      end
      OP_RL_A:   info_o.alu_code = ALU_RL;
      OP_RLC_A: begin
        info_o.alu_code  = ALU_RLC;
        info_o.flag_mask = MASK_CY;
      end
      default:   info_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mcu51_alu_seq.sv
// Accumulator-class instruction sequencer: takes opcode/immediate bytes, feeds
// registered operands to the external ALU and writes results back to ACC/PSW.
module mcu51_alu_seq
  import mcu51_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [7:0] code_data,
  output logic       code_ready,
  input  logic       acc_load,
  input  logic [7:0] acc_load_data,
  input  logic [2:0] flag_load_data,
  output logic [3:0] alu_code,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cy,
  output logic       alu_ac,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_acarry,
  input  logic       alu_ovf,
  output logic [7:0] acc,
  output logic       psw_cy,
  output logic       psw_ac,
  output logic       psw_ov,
  output logic       psw_p,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  state_e     state_q, state_d;
  op_info_t   dec;
  logic [7:0] acc_q, acc_d;
  logic       cy_q, cy_d, ac_q, ac_d, ov_q, ov_d;
  logic [3:0] alu_code_q;
  flag_mask_t mask_q;
  logic [7:0] alu_a_q, alu_b_q;
  logic       alu_cy_q, alu_ac_q;
  logic       done_q, illegal_q;
  logic       load_op, load_imm, enter_exec, writeback, illegal_d;

  mcu51_op_decode u_decode (
    .opcode_i (code_data),
    .info_o   (dec)
  );

  always_comb begin
    state_d    = state_q;
    code_ready = 1'b0;
    load_op    = 1'b0;
    load_imm   = 1'b0;
    enter_exec = 1'b0;
    writeback  = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: begin
        code_ready = 1'b1;
        if (code_valid) begin
          if (!dec.legal) begin
            illegal_d = 1'b1;
          end else begin
            load_op = 1'b1;
            if (dec.two_byte) begin
              state_d = IMM;
            end else begin
              state_d    = EXEC;
              enter_exec = 1'b1;
            end
          end
        end
      end
      IMM: begin
        code_ready = 1'b1;
        if (code_valid) begin
          load_imm   = 1'b1;
          enter_exec = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        writeback = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A load in IDLE lands in *_d, so an opcode accepted in the same cycle
  // captures the freshly loaded ACC/flags as its operands.
  always_comb begin
    acc_d = acc_q;
    cy_d  = cy_q;
    ac_d  = ac_q;
    ov_d  = ov_q;
    if (state_q == IDLE && acc_load) begin
      acc_d = acc_load_data;
      {cy_d, ac_d, ov_d} = flag_load_data;
    end
    if (writeback) begin
      acc_d = alu_result;
      if (mask_q.cy_en) cy_d = alu_carry;
      if (mask_q.ac_en) ac_d = alu_acarry;
      if (mask_q.ov_en) ov_d = alu_ovf;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= 8'h00;
      cy_q       <= 1'b0;
      ac_q       <= 1'b0;
      ov_q       <= 1'b0;
      alu_code_q <= ALU_INC;
      mask_q     <= MASK_NONE;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      alu_cy_q   <= 1'b0;
      alu_ac_q   <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cy_q      <= cy_d;
      ac_q      <= ac_d;
      ov_q      <= ov_d;
      done_q    <= writeback;
      illegal_q <= illegal_d;
      if (load_op) begin
        alu_code_q <= dec.alu_code;
        mask_q     <= dec.flag_mask;
        alu_b_q    <= 8'h00;
      end
      if (load_imm) alu_b_q <= code_data;
      if (enter_exec) begin
        alu_a_q  <= acc_d;
        alu_cy_q <= cy_d;
        alu_ac_q <= ac_d;
      end
    end
  end

  assign alu_code = alu_code_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_cy   = alu_cy_q;
  assign alu_ac   = alu_ac_q;
  assign acc      = acc_q;
  assign psw_cy   = cy_q;
  assign psw_ac   = ac_q;
  assign psw_ov   = ov_q;
  assign psw_p    = ^acc_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign illegal  = illegal_q;

endmodule

// File: doc/mcu51_alu_seq.md
# mcu51_alu_seq

Instruction-stream sequencer that drives the MCU51 ALU from the control side. It accepts 8051 accumulator-class opcode bytes (plus an immediate byte where required) over a valid/ready byte stream. It decodes each opcode to an ALU operation code, presents registered operands and carry inputs to the ALU, and writes the ALU result back into its own accumulator and PSW flag register. It sits between the code-fetch unit and the ALU and owns ACC, CY, AC, OV and P.

## Interface
- No parameters; data width fixed at 8.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- code_valid  in  1  code byte available
- code_data  in  8  opcode or immediate byte
- code_ready  out  1  sequencer accepts a byte this cycle
- acc_load  in  1  load ACC and flags; honoured only when busy=0
- acc_load_data  in  8  ACC value to load
- flag_load_data  in  3  {CY,AC,OV} to load with acc_load
- alu_code  out  4  ALU op select to ALU (registered)
- alu_a, alu_b  out  8  ALU operands (registered)
- alu_cy, alu_ac  out  1  current CY/AC to ALU (registered)
- alu_result  in  8  ALU result
- alu_carry, alu_acarry, alu_ovf  in  1  ALU flag outputs
- acc  out  8  accumulator
- psw_cy, psw_ac, psw_ov, psw_p  out  1  flags; P = even parity of acc (XOR of bits)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, instruction retired
- illegal  out  1  one-cycle pulse, unsupported opcode dropped

## Operation
- Supported opcodes → ALU code. Each entry lists flags written:
  - 0x04 INC A → 0000, none
  - 0x14 DEC A → 0001, none
  - 0x24 ADD #i → 0010, CY AC OV
  - 0x34 ADDC #i → 0011, CY AC OV
  - 0x44 ORL #i → 0100, none
  - 0x54 ANL #i → 0101, none
  - 0x64 XRL #i → 0110, none
  - 0xF4 CPL A → 0111, none
  - 0xD4 DA A → 1000, CY only
  - 0x94 SUBB #i → 1001, CY AC OV
  - 0x03 RR → 1100, none
  - 0x13 RRC → 1101, CY
  - 0x23 RL → 1110, none
  - 0x33 RLC → 1111, CY
- "#i" opcodes are two-byte; the immediate drives alu_b. One-byte ops drive alu_b=0x00.
- alu_a = acc, alu_cy = psw_cy and alu_ac = psw_ac, all captured when entering EXEC.
- Any other opcode: byte consumed, illegal pulses, ACC/flags untouched.
- State machine:
  - IDLE: code_ready=1. On handshake, latch the opcode. Two-byte legal → IMM. One-byte legal → EXEC. Illegal → stay IDLE.
  - IMM: code_ready=1. Wait any number of cycles for code_valid; latch the immediate → EXEC.
  - EXEC: code_ready=0. At end of cycle, acc ← alu_result and the flag mask is applied → IDLE.
- Flags not in the mask retain their value. P is recomputed combinationally from acc at all times.
- acc_load while busy=1 is ignored. In IDLE, acc_load and a code handshake in the same cycle are both honoured: the load updates ACC/flags, and the opcode executes against the loaded values.

## Timing
- Reset: acc=0x00, CY=AC=OV=0, P=0, alu_code=0000, alu_a=alu_b=0x00, alu_cy=alu_ac=0, done=0, illegal=0, state IDLE, code_ready=1 after release.
- One-byte op: handshake in cycle T, EXEC in T+1, new acc/flags and done=1 in T+2, next opcode accepted in T+2.
- Two-byte op with back-to-back bytes: opcode in T, immediate in T+1, EXEC in T+2, done in T+3.
- illegal is asserted in the cycle after the offending handshake. A new opcode is accepted in that same cycle.
- Reset asserted in IMM or EXEC aborts the instruction: no writeback, no done.
- The ALU is combinational. The sequencer samples alu_* inputs only in EXEC.

## Structure
- Shared package mcu51_pkg holds:
  - ALU code constants, 4 bits, values as listed above
  - opcode constants
  - state enum {IDLE, IMM, EXEC}
  - flag-mask encoding {cy_en, ac_en, ov_en}
- Sub-module mcu51_op_decode (combinational) maps opcode → {legal, two_byte, alu_code, flag_mask}. The FSM, operand registers and ACC/PSW live in the top.

## Test plan
- Reset: acc=0x00, all flags 0, code_ready=1, busy=0.
- Load ACC=0x01, flags 0; send 0x24,0x7F → acc=0x80, CY=0, AC=1, OV=1, P=1. done occurs 3 cycles after the opcode handshake.
- Load ACC=0x00, CY=1; send 0x94,0x00 → acc=0xFF, CY=1, AC=1, OV=0, P=0.
- Load ACC=0xA0, CY=0, AC=0; send 0xD4 → acc=0x00, CY=1, AC unchanged. Then send 0x33 (RLC) → acc=0x01, CY=0.
- Send 0xA5 → illegal pulse, acc unchanged. 0x04 sent in the following cycle is accepted and gives acc+1.
- Send 0x44, hold code_valid low 5 cycles, then 0x0F → busy held throughout, result ACC|0x0F. Repeat with rst_n pulsed during the gap → no done, acc=0x00.
